// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbiter that shares one 8-bit adder/subtractor
// between two requesters.
//
// Each operation takes three cycles: IDLE (arbitrate) -> EXEC (compute) -> DONE.
// The winner's operands are latched on the grant edge. The result is registered
// on the EXEC edge and returned with a one-cycle rsp_valid pulse to the owner.
//
// Optional feature: define ADDSUB_ARB_SAT_EN to saturate the result when ovf=1.
// An add saturates to 8'hFF and a subtract to 8'h00. carry and ovf keep the raw
// adder values.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req0/op0/a0/b0      requester 0: level request, op (0 add, 1 a-b), operands
//   req1/op1/a1/b1      requester 1: same as requester 0
//   gnt0/gnt1           one-cycle pulse: operands captured for that requester
//   rsp_valid0/1        one-cycle pulse: result/carry/ovf valid for that requester
//   result, carry, ovf  registered datapath outputs; held until the next EXEC edge
//   busy                high whenever the FSM is not in IDLE
module addsub_arbiter #(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       op0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic       req1,
  input  logic       op1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rsp_valid0,
  output logic       rsp_valid1,
  output logic [7:0] result,
  output logic       carry,
  output logic       ovf,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;
  logic       op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;

  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       rsp0_q, rsp0_d;
  logic       rsp1_q, rsp1_d;
  logic [7:0] result_q, result_d;
  logic       carry_q, carry_d;
  logic       ovf_q, ovf_d;
  logic       busy_q, busy_d;

  logic       any_req;
  logic       winner;
  logic [7:0] b_eff;
  logic [8:0] sum;
  logic       ovf_raw;

  // Arbitration: a lone request wins outright; on a tie the requester that
  // did not win last time goes first.
  always_comb begin
    any_req = req0 | req1;
    winner  = 1'b0;
    if (req0 && req1) begin
      winner = ~last_grant_q;
    end else begin
      winner = req1;
    end
  end

  // Shared adder/subtractor: sel=1 computes a + ~b + 1.
  always_comb begin
    b_eff   = op_q ? ~b_q : b_q;
    sum     = {1'b0, a_q} + {1'b0, b_eff} + {8'd0, op_q};
    // Add overflows on carry out; subtract underflows on borrow (carry=0).
    ovf_raw = op_q ? ~sum[8] : sum[8];
  end

  // Next-state logic and operand capture.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d      = StExec;
          owner_d      = winner;
          last_grant_d = winner;
          op_d         = winner ? op1 : op0;
          a_d          = winner ? a1 : a0;
          b_d          = winner ? b1 : b0;
        end
      end
      StExec:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values for the registered outputs.
  always_comb begin
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    rsp0_d   = 1'b0;
    rsp1_d   = 1'b0;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    busy_d   = (state_d != StIdle);
    if (state_q == StIdle && any_req) begin
      gnt0_d = ~winner;
      gnt1_d = winner;
    end
    if (state_q == StExec) begin
      rsp0_d  = ~owner_q;
      rsp1_d  = owner_q;
      carry_d = sum[8];
      ovf_d   = ovf_raw;
`ifdef ADDSUB_ARB_SAT_EN
      if (ovf_raw) begin
        result_d = op_q ? 8'h00 : 8'hFF;
      end else begin
        result_d = sum[7:0];
      end
`else
      result_d = sum[7:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= ~RESET_PRIO;
      op_q         <= 1'b0;
      a_q          <= 8'd0;
      b_q          <= 8'd0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rsp0_q       <= 1'b0;
      rsp1_q       <= 1'b0;
      result_q     <= 8'd0;
      carry_q      <= 1'b0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      rsp0_q       <= rsp0_d;
      rsp1_q       <= rsp1_d;
      result_q     <= result_d;
      carry_q      <= carry_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign rsp_valid0 = rsp0_q;
  assign rsp_valid1 = rsp1_q;
  assign result     = result_q;
  assign carry      = carry_q;
  assign ovf        = ovf_q;
  assign busy       = busy_q;

endmodule
